// File: rtl/pdp1_sbs_multi.sv
`default_nettype none
// ============================================================================
// Module   : pdp1_sbs_multi
// Brief    : Multi-channel sequence-break (priority interrupt) controller for
//            the PDP-1 core. Latches device break strobes, qualifies them
//            against per-channel arm bits, a global enable and nesting
//            priority (channel 0 highest), and hands one channel at a time to
//            the CPU break sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module pdp1_sbs_multi #(
  parameter int CHANNELS = 16,
  parameter int CHW      = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                pb_att,
  input  logic [0:10]         pb_op,
  input  logic [0:CHW-1]      pb_chan,
  input  logic [0:CHANNELS-1] tr_req,
  output logic                sb_ireq,
  output logic [0:CHW-1]      sb_chan,
  input  logic                sb_ack,
  input  logic                sb_ret,
  output logic [0:CHANNELS]   pb_sqb
);

  localparam logic        C_ST_IDLE = 1'b0;
  localparam logic        C_ST_REQ  = 1'b1;

  localparam logic [0:10] C_OP_DSC  = 11'o0050;
  localparam logic [0:10] C_OP_ASC  = 11'o0051;
  localparam logic [0:10] C_OP_ISB  = 11'o0052;
  localparam logic [0:10] C_OP_CAC  = 11'o0053;
  localparam logic [0:10] C_OP_LSM  = 11'o0054;
  localparam logic [0:10] C_OP_ESM  = 11'o0055;
  localparam logic [0:10] C_OP_CBS  = 11'o0056;

  logic                state_q, state_d;
  logic                en_q, en_d;
  logic [0:CHANNELS-1] arm_q, arm_d;
  logic [0:CHANNELS-1] req_q, req_d;
  logic [0:CHANNELS-1] act_q, act_d;
  logic [0:CHANNELS-1] trd_q, trd_d;
  logic                sb_ireq_q, sb_ireq_d;
  logic [0:CHW-1]      sb_chan_q, sb_chan_d;

  logic [0:CHANNELS-1] w_edge;
  logic [0:CHANNELS-1] w_elig;
  logic                w_win_vld;
  logic [0:CHW-1]      w_win_chan;
  logic                w_cur_elig;
  logic                w_ack_take;

  // State register: all flops, synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= C_ST_IDLE;
      en_q      <= 1'b0;
      arm_q     <= '0;
      req_q     <= '0;
      act_q     <= '0;
      trd_q     <= '0;
      sb_ireq_q <= 1'b0;
      sb_chan_q <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      arm_q     <= arm_d;
      req_q     <= req_d;
      act_q     <= act_d;
      trd_q     <= trd_d;
      sb_ireq_q <= sb_ireq_d;
      sb_chan_q <= sb_chan_d;
    end
  end

  // Eligibility from pre-IOT register values; a channel is blocked by any
  // in-service channel of equal or higher priority. Lowest eligible wins.
  always_comb begin : p_elig
    logic blk;
    blk        = 1'b0;
    w_edge     = tr_req & ~trd_q;
    w_elig     = '0;
    w_win_vld  = 1'b0;
    w_win_chan = '0;
    w_cur_elig = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      blk       = blk | act_q[i];
      w_elig[i] = req_q[i] & arm_q[i] & en_q & ~blk;
    end
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_win_vld  = 1'b1;
        w_win_chan = CHW'(i);
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (sb_chan_q == CHW'(i)) begin
        w_cur_elig = w_elig[i];
      end
    end
  end

  // Channel state update: return, then ack, then IOT, then device edges
  // (an edge always wins for that channel's req bit).
  always_comb begin : p_chan
    logic found;
    found      = 1'b0;
    en_d       = en_q;
    arm_d      = arm_q;
    req_d      = req_q;
    act_d      = act_q;
    trd_d      = tr_req;
    w_ack_take = (state_q == C_ST_REQ) & sb_ack;

    if (sb_ret) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (act_q[i] && !found) begin
          act_d[i] = 1'b0;
          found    = 1'b1;
        end
      end
    end

    if (w_ack_take) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sb_chan_q == CHW'(i)) begin
          act_d[i] = 1'b1;
          req_d[i] = 1'b0;
        end
      end
    end

    // Out-of-range channel operands match no loop index and are ignored.
    if (pb_att) begin
      case (pb_op)
        C_OP_ESM: en_d = 1'b1;
        C_OP_LSM: en_d = 1'b0;
        C_OP_CAC: arm_d = '0;
        C_OP_CBS: begin
          req_d = '0;
          act_d = '0;
        end
        C_OP_DSC, C_OP_ASC, C_OP_ISB: begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (pb_chan == CHW'(i)) begin
              if (pb_op == C_OP_DSC) arm_d[i] = 1'b0;
              if (pb_op == C_OP_ASC) arm_d[i] = 1'b1;
              if (pb_op == C_OP_ISB) req_d[i] = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    req_d = req_d | w_edge;
  end

  // Next-state logic: request on a winner, leave REQ on ack or withdrawal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_IDLE: if (w_win_vld) state_d = C_ST_REQ;
      C_ST_REQ:  if (sb_ack || !w_cur_elig) state_d = C_ST_IDLE;
      default:   state_d = C_ST_IDLE;
    endcase
  end

  // Output logic: registered request/channel; IDLE forces a low cycle.
  always_comb begin
    sb_ireq_d = 1'b0;
    sb_chan_d = sb_chan_q;
    case (state_q)
      C_ST_IDLE: begin
        if (w_win_vld) begin
          sb_ireq_d = 1'b1;
          sb_chan_d = w_win_chan;
        end
      end
      C_ST_REQ:  sb_ireq_d = ~sb_ack & w_cur_elig;
      default:   ;
    endcase
  end

  assign sb_ireq = sb_ireq_q;
  assign sb_chan = sb_chan_q;
  assign pb_sqb  = {en_q, act_q};

endmodule
`default_nettype wire

// File: doc/pdp1_sbs_multi.md
# pdp1_sbs_multi

Parametrised multi-channel sequence-break (priority interrupt) controller for the PDP-1 core, the successor to the single-level break unit. It latches break requests from up to 16 I/O devices and qualifies each against a per-channel arm bit, a global enable and channel priority. Channel 0 has the highest priority. Breaks nest by priority: a channel can interrupt only while no equal- or higher-priority channel is in service. It sits between the device transfer strobes, the IOT decode bus and the CPU break sequencer.

## Interface
- CHANNELS, 16, number of break channels, 1..16; channel 0 has highest priority
- CHW, 4, channel-number width; the legal CHANNELS range must fit in CHW bits
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- pb_att  in  1  IOT attention, one-cycle strobe qualifying pb_op/pb_chan
- pb_op  in  [0:10]  IOT opcode
- pb_chan  in  [0:CHW-1]  channel operand of channel-directed IOTs
- tr_req  in  [0:CHANNELS-1]  device break strobes; bit i is channel i; rising-edge sensitive
- sb_ireq  out  1  break request to CPU, registered
- sb_chan  out  [0:CHW-1]  channel being requested; valid while sb_ireq=1
- sb_ack  in  1  one-cycle pulse: CPU has entered the break for sb_chan
- sb_ret  in  1  one-cycle pulse: CPU executed return-from-break
- pb_sqb  out  [0:CHANNELS]  status: bit 0 = global enable; bits 1..CHANNELS = in-service bits of channels 0..CHANNELS-1

## Operation
- Per-channel state: req (pending), arm (enabled) and act (in service). Global state: en, plus the tr_req delay register used for edge detection.
- Request capture: a rising edge on tr_req[i] sets req[i]. Capture is independent of en and arm, so requests persist until they are serviced or cleared.
- IOTs act only when pb_att=1. Any opcode not listed is ignored.
  - 0055 esm: en<=1.
  - 0054 lsm: en<=0.
  - 0056 cbs: clear all req and all act.
  - 0050 dsc: arm[pb_chan]<=0.
  - 0051 asc: arm[pb_chan]<=1.
  - 0052 isb: req[pb_chan]<=1 (software-initiated break).
  - 0053 cac: clear all arm.
  - A pb_chan value >= CHANNELS is ignored for dsc, asc and isb.
- Eligibility: channel i is eligible when req[i] & arm[i] & en, and no act[j] is set for any j<=i.
- Winner: the lowest-numbered eligible channel.
- States:
  - IDLE: when a winner w exists, register sb_chan<=w and sb_ireq<=1, then go to REQ.
  - REQ: sb_chan holds steady.
    - On sb_ack: act[sb_chan]<=1, req[sb_chan]<=0, sb_ireq<=0, go to IDLE.
    - If the requested channel stops being eligible without an ack (lsm, dsc, cbs, cac), drop sb_ireq and go to IDLE. Re-arbitration happens from IDLE on the next cycle.
  - A higher-priority channel becoming eligible during REQ does not preempt; the CPU services the latched channel.
- sb_ret clears the lowest-numbered set act bit. It has no effect when no act bit is set. It is processed in any state.
- sb_ack while in IDLE is ignored.

## Timing
- Reset values: sb_ireq=0, sb_chan=0, pb_sqb all 0. Also en=0, all arm=0, all req=0, all act=0, and the tr_req delay register=0. A high tr_req during reset therefore produces an edge on the first cycle after reset.
- Reset asserted mid-break (REQ) aborts the request; the state returns to IDLE the next cycle.
- Latency: a tr_req edge sampled at cycle t sets req at t+1. With the channel eligible, sb_ireq=1 at t+2. An isb accepted at t gives sb_ireq=1 at t+2.
- sb_ireq stays low for at least one cycle between consecutive requests.
- Simultaneous events in one cycle:
  - A tr_req edge and sb_ack for the same channel: the set wins, req stays 1 and the channel breaks again after return.
  - cbs and a tr_req edge: the edge wins for that channel's req.
  - sb_ack and sb_ret: ret clears first, then ack sets act[sb_chan].
  - An IOT is applied in the same cycle as the state-machine update, so eligibility uses the pre-IOT values.
- pb_sqb is a direct view of the registers and has no extra latency.

## Test plan
- Reset, then esm, then asc ch3, then a tr_req[3] edge → sb_ireq=1 with sb_chan=3 exactly 2 cycles after the edge. Ack → pb_sqb bit 4=1 and sb_ireq=0. sb_ret → bit 4=0.
- Arm ch2 and ch5 and pulse both together → ch2 is served first. While ch2 is active, ch5 gets no request. After sb_ret, ch5 is requested with sb_chan=5.
- Nesting: ch5 active, then a ch1 edge → sb_ireq with sb_chan=1 while act5 stays set. Two sb_ret pulses clear act1 first, then act5.
- Gating: an edge on unarmed ch7 with en=0 → no request. esm alone → still none. asc ch7 → sb_chan=7, because req persisted.
- Withdrawal: in REQ for ch4, issue dsc ch4 → sb_ireq drops the next cycle, and a later ack is ignored.
- Edge cases: isb with pb_chan=15 when CHANNELS=8 → no effect. A tr_req edge in the same cycle as sb_ack on that channel → second break after sb_ret. i_rst during REQ → all outputs 0.
